// File: rtl/decoder_rr_scheduler.sv
// Round-robin owner scheduler for the shared 3-to-8 decoder with quantum and break-before-make gap.
// Optional ARB_LOCK_EN adds a lock input that suppresses quantum release while asserted.
module decoder_rr_scheduler #(
    parameter int QUANTUM = 16,
    parameter int GAP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [2:0] sel,
    output logic       oe,
    output logic [7:0] grant,
    output logic       busy
);

    localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(QUANTUM - 1);
    localparam logic [GW-1:0] GAP_LD  = GW'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

    state_t        state;
    logic [2:0]    ptr;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gcnt;

    logic [2:0] win;
    logic [2:0] idx;
    logic       any;
    logic       q_hit;
    logic       rel;

    // Scan from the farthest offset down so the nearest set bit after ptr wins.
    always_comb begin
        win = ptr;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) win = idx;
        end
    end

    assign any = |req;

`ifdef ARB_LOCK_EN
    assign q_hit = (cnt == CNT_MAX) && (|(req & ~grant)) && !lock;
`else
    assign q_hit = (cnt == CNT_MAX) && (|(req & ~grant));
`endif

    assign rel = !req[sel] || q_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sel   <= '0;
            oe    <= 1'b0;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
            gcnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any) begin
                        state <= S_GRANT;
                        sel   <= win;
                        oe    <= 1'b1;
                        grant <= 8'b1 << win;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                S_GRANT: begin
                    if (rel) begin
                        state <= S_GAP;
                        oe    <= 1'b0;
                        grant <= '0;
                        ptr   <= sel + 3'd1;
                        gcnt  <= GAP_LD;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (gcnt == '0) begin
                        if (any) begin
                            state <= S_GRANT;
                            sel   <= win;
                            oe    <= 1'b1;
                            grant <= 8'b1 << win;
                            cnt   <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gcnt <= gcnt - GW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    oe    <= 1'b0;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// Bench for decoder_rr_scheduler: directed scenarios plus random traffic against an owner/tenure model.
module tb_decoder_rr_scheduler;

    localparam int QUANTUM = 4;
    localparam int GAP     = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       lock = 1'b0;
    logic [2:0] sel;
    logic       oe;
    logic [7:0] grant;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Model: who owns the decoder, how long they have held it, gap cycles left.
    int m_owner = -1;
    int m_ten   = 0;
    int m_gap   = 0;
    int m_ptr   = 0;
    int m_sel   = 0;

    always #5 clk = ~clk;

    decoder_rr_scheduler #(.QUANTUM(QUANTUM), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .sel   (sel),
        .oe    (oe),
        .grant (grant),
        .busy  (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    function automatic bit lock_now();
`ifdef ARB_LOCK_EN
        return lock;
`else
        return 1'b0;
`endif
    endfunction

    // Advance the model by one rising edge using the inputs presented at that edge.
    task automatic model_step();
        int w;
        if (!rst_n) begin
            m_owner = -1; m_ten = 0; m_gap = 0; m_ptr = 0; m_sel = 0;
        end else if (m_owner >= 0) begin
            m_ten++;
            if (!req[m_owner] ||
                (m_ten >= QUANTUM && (req & ~(8'h01 << m_owner)) != 8'h00 && !lock_now())) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_gap   = GAP;
            end
        end else begin
            if (m_gap > 0) m_gap--;
            if (m_gap == 0) begin
                w = pick(req, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_sel = w; m_ten = 0;
                end
            end
        end
    endtask

    task automatic tick();
        logic [7:0] eg;
        @(negedge clk);
        model_step();
        eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        chk("sel",   32'(sel),   32'(m_sel));
        chk("oe",    32'(oe),    32'(m_owner >= 0));
        chk("grant", 32'(grant), 32'(eg));
        chk("busy",  32'(busy),  32'(m_owner >= 0 || m_gap > 0));
        chk("onehot", 32'($countones(grant) <= 1), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] mask;
        // Reset held with all requests high: outputs stay quiet.
        rst_n = 1'b0; req = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out", {sel, oe, grant, busy}, 32'h0);
        end

        // Single requester 2, then drop: one gap cycle then idle.
        rst_n = 1'b1; req = 8'h04;
        tick();
        chk("t2_grant", 32'(grant), 32'h04);
        chk("t2_sel", 32'(sel), 32'd2);
        for (int i = 0; i < 3; i++) tick();
        req = 8'h00;
        tick();
        chk("t2_gap", {oe, grant, busy}, 32'h1);
        tick();
        chk("t2_idle", 32'(busy), 32'd0);
        chk("t2_selhold", 32'(sel), 32'd2);

        // All requesting: owners 0..7,0 each QUANTUM cycles plus one gap cycle.
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 45; k++) begin
            tick();
            if (k % 5 < 4) chk("t3_grant", 32'(grant), 32'(8'h01 << ((k / 5) % 8)));
            else           chk("t3_gap", 32'(oe), 32'd0);
        end

        // Requesters 0 and 7 alternate across the wrap.
        do_reset();
        req = 8'h81;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k % 5 < 4) chk("t4_grant", 32'(grant), ((k / 5) % 2) ? 32'h80 : 32'h01);
            else           chk("t4_gap", 32'(oe), 32'd0);
        end

        // Lone requester keeps the grant past the quantum.
        do_reset();
        req = 8'h10;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("t5_hold", {oe, grant}, 32'h110);
        end

`ifdef ARB_LOCK_EN
        do_reset();
        req = 8'h03; lock = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t6_lock", 32'(grant), 32'h01);
        end
        lock = 1'b0;
        tick();
        chk("t6_rel", 32'(oe), 32'd0);
        tick();
        chk("t6_next", 32'(grant), 32'h02);
        rst_n = 1'b0;
        tick();
        chk("t6_rst", {sel, oe, grant, busy}, 32'h0);
        rst_n = 1'b1;
`endif

        // Random traffic: sparse toggles so owners drop and compete.
        do_reset();
        req = 8'h00;
        for (int k = 0; k < 3000; k++) begin
            mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
            req   = req ^ mask;
            rst_n = ($urandom_range(0, 249) != 0);
            lock  = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
